// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct constants, fetch state encoding and PC step
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [31:0] PC_INC  = 32'd4;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetch_state_e;
endpackage

// File: rtl/mips_fetch.sv
// mips_fetch: PC owner issuing one in-flight imem read, holding the fetched word for decode; MIPS_FETCH_PERF_EN adds perf counters
module mips_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MIPS_FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [5:0]  inst_opcode,
    output logic [5:0]  inst_funct,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_data_q, inst_data_d, inst_pc_q, inst_pc_d;
    logic        drop_q, drop_d, inst_valid_q, inst_valid_d;

    assign imem_req_valid = state_q == S_REQ;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign inst_opcode    = inst_data_q[31:26];
    assign inst_funct     = inst_data_q[5:0];

    // next state: a redirect always wins on pc and kills any held or in-flight instruction
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                state_d = imem_req_ready ? S_WAIT : S_REQ;
                drop_d  = imem_req_ready && redirect_valid;
            end
            S_WAIT: begin
                if (imem_resp_valid && (drop_q || redirect_valid)) begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end else if (imem_resp_valid) begin
                    inst_data_d  = imem_resp_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + PC_INC;
                    state_d      = S_HOLD;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                inst_valid_d = !(inst_ready || redirect_valid);
                state_d      = (inst_ready || redirect_valid) ? S_REQ : S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) pc_d = redirect_pc & ~32'h3;
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    // count delivered instructions and cycles spent waiting on memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'd0, inst_valid_q && inst_ready && !redirect_valid};
            perf_stall_q   <= perf_stall_q + {31'd0, (state_q == S_REQ && !imem_req_ready) || state_q == S_WAIT};
        end
    end
`endif
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: randomized memory/decode/redirect traffic against an architectural next-PC scoreboard
module tb_mips_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic        inst_valid, inst_ready, redirect_valid;
    logic [31:0] inst_data, inst_pc, redirect_pc;
    logic [5:0]  inst_opcode, inst_funct;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
    int          fetched_model = 0;
`endif
    int          vectors = 0;
    int          miscompares = 0;
    int          transfers = 0;
    logic [31:0] exp_q[$];
    logic        hold_prev = 1'b0, req_prev = 1'b0;
    logic [31:0] pdata, ppc, paddr_prev;
    logic        pend = 1'b0;
    logic [31:0] paddr;
    int          pcnt;

    mips_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
`ifdef MIPS_FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall),
`endif
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .inst_opcode(inst_opcode),
        .inst_funct(inst_funct),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares every delivered instruction and every request against the scoreboard
    always @(negedge clk) begin
        logic [31:0] e, w;
        if (rst) begin
            hold_prev = 1'b0;
            req_prev  = 1'b0;
`ifdef MIPS_FETCH_PERF_EN
            fetched_model = 0;
`endif
        end else begin
            e = exp_q.size() != 0 ? exp_q[0] : 32'hxxxx_xxxx;
            if (req_prev) begin
                check("req_held_valid", {31'd0, imem_req_valid}, 32'd1);
                check("req_held_addr", imem_req_addr, paddr_prev);
            end
            if (imem_req_valid && !redirect_valid) check("req_addr", imem_req_addr, e);
            if (hold_prev) begin
                check("hold_valid", {31'd0, inst_valid}, 32'd1);
                check("hold_data", inst_data, pdata);
                check("hold_pc", inst_pc, ppc);
            end
`ifdef MIPS_FETCH_PERF_EN
            check("perf_fetched", perf_fetched, fetched_model);
`endif
            if (inst_valid && inst_ready && !redirect_valid) begin
                w = mem_word(e);
                check("inst_pc", inst_pc, e);
                check("inst_data", inst_data, w);
                check("inst_opcode", {26'd0, inst_opcode}, {26'd0, w[31:26]});
                check("inst_funct", {26'd0, inst_funct}, {26'd0, w[5:0]});
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                exp_q.push_back(e + 32'd4);
                transfers++;
`ifdef MIPS_FETCH_PERF_EN
                fetched_model++;
`endif
            end
            hold_prev  = inst_valid && !inst_ready && !redirect_valid;
            req_prev   = imem_req_valid && !imem_req_ready && !redirect_valid;
            pdata      = inst_data;
            ppc        = inst_pc;
            paddr_prev = imem_req_addr;
        end
    end

    // driver: memory with random latency, random decode back-pressure, redirects and reset pulses
    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exp_q = {RESET_PC};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (imem_resp_valid) pend = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                paddr = imem_req_addr;
                pcnt  = $urandom_range(0, 3);
            end
            @(posedge clk);
            #1;
            rst = !rst && $urandom_range(0, 299) == 0;
            if (rst) exp_q = {RESET_PC};
            imem_req_ready = !pend && $urandom_range(0, 3) != 0;
            if (pend && pcnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(paddr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
                if (pend) pcnt--;
            end
            inst_ready = $urandom_range(0, 1) == 1;
            redirect_valid = !rst && $urandom_range(0, 11) == 0;
            redirect_pc = $urandom_range(0, 2) == 0 ? 32'hFFFF_FFF8 | $urandom_range(0, 7) : $urandom;
            if (redirect_valid) exp_q = {redirect_pc & ~32'h3};
        end
        @(negedge clk);
        check("progress", {31'd0, transfers >= 200}, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mips_fetch.md
Name: mips_fetch

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC and issues word reads to instruction memory over a valid/ready request and a valid-only response.
- Holds each fetched instruction in an output register, presented with a valid/ready handshake to decode, together with split opcode/funct fields.
- Accepts a branch/jump redirect from downstream and discards any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
- imem_resp_valid  in  1  read data valid; at most one response per accepted request, in order.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  output instruction valid.
- inst_ready  in  1  decode consumes the instruction this cycle.
- inst_data  out  32  instruction word.
- inst_pc  out  32  address of inst_data.
- inst_opcode  out  6  inst_data[31:26].
- inst_funct  out  6  inst_data[5:0].
- redirect_valid  in  1  taken branch/jump.
- redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset values:
  - state S_IDLE; pc = RESET_PC; drop = 0.
  - inst_valid = 0; inst_data, inst_pc = 0.
  - imem_req_valid = 0.
- States and transitions:
  - S_IDLE: imem_req_valid = 0. Always goes to S_REQ next cycle (first request one cycle after rst deasserts).
  - S_REQ: imem_req_valid = 1 and imem_req_addr = pc, both held stable until imem_req_ready. On accept, go to S_WAIT.
  - S_WAIT: wait for imem_resp_valid.
    - If drop = 0: capture imem_resp_data into inst_data and pc into inst_pc; set inst_valid; pc <= pc + 4; go to S_HOLD.
    - If drop = 1: discard the response; clear drop; go to S_REQ.
  - S_HOLD: inst_valid = 1; outputs stable. On inst_valid && inst_ready: clear inst_valid and go to S_REQ (the next request is issued in the following cycle).
- Latency: inst_valid rises the cycle after imem_resp_valid. Minimum 3 cycles per instruction with zero-wait memory.
- PC arithmetic: pc + 4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0.
- Redirect (highest priority, any state): pc <= {redirect_pc[31:2], 2'b00}.
  - In S_IDLE: only pc updates.
  - In S_REQ without accept: go to (or stay in) S_REQ; the new address appears the next cycle.
  - In S_REQ with accept in the same cycle: the request counts as in flight; go to S_WAIT with drop = 1.
  - In S_WAIT: set drop = 1. If the response arrives in the same cycle, discard it and go to S_REQ.
  - In S_HOLD: clear inst_valid even if inst_ready = 1 that cycle; go to S_REQ.
- Redirect and inst_ready together: the handshake is void; decode must not consume that cycle's instruction.
- A response in S_IDLE, S_REQ or S_HOLD is a protocol error and is ignored.
- inst_opcode and inst_funct are continuous slices of inst_data.
- rst asserted mid-operation: all state returns to reset values immediately. An outstanding response arriving after reset finds S_IDLE or S_REQ and is ignored.

Optional Feature:
- Macro: MIPS_FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32, increments on each inst_valid && inst_ready transfer not voided by redirect) and perf_stall (32, increments each cycle in S_REQ with !imem_req_ready or in S_WAIT). Both counters clear on rst and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- mips_pkg holds:
  - opcode constants OP_RTYPE=6'h0, OP_J=6'h2, OP_BEQ=6'h4, OP_ADDI=6'h8, OP_LW=6'h23, OP_SW=6'h2b;
  - funct constants for sll/add/sub/and/or/slt;
  - fetch state enum (S_IDLE, S_REQ, S_WAIT, S_HOLD);
  - PC_INC = 32'd4.
- Single module; no sub-module. Perf counters stay inline under the macro.

Test Plan:
- Reset release, zero-wait memory returning 32'h2008_0005 at addr 0 → req addr 0 two cycles after rst falls; inst_valid with inst_pc=0, opcode 6'h08, funct 6'h05; next req addr 4.
- inst_ready held 0 for 5 cycles while in S_HOLD → inst_data, inst_pc, inst_valid stable; no new request issued; transfer on ready, then req addr = previous pc + 4.
- redirect_pc=32'h0000_0103 asserted in S_WAIT; response 32'hDEAD_BEEF arrives 2 cycles later → response dropped, inst_valid stays 0; next req addr 32'h100; next instruction's inst_pc = 32'h100.
- redirect in the same cycle as inst_valid && inst_ready → instruction voided; next req addr = redirect target; perf_fetched unchanged (MIPS_FETCH_PERF_EN defined).
- RESET_PC=32'hFFFF_FFFC, one fetch completes → next req addr 32'h0000_0000.
- rst pulsed while in S_WAIT, stale response arrives in S_IDLE → ignored; inst_valid 0; first post-reset req addr = RESET_PC.
